quote_scheduler: RTL and testbench

- Sequences bid/ask quote pairs from the quote pricing stage onto the single-lane order gateway interface.
- Each valid quote pair is emitted as two beats over a valid/ready handshake: bid beat first, then ask beat.
- Enforces a minimum cooldown between quote pairs and keeps only the latest pending quote (latest-wins).
- Rejects crossed quotes (buy >= ask) and counts dropped quotes.

---
 rtl/quote_scheduler.sv | 146 ++++++++++++++
 tb/tb_quote_scheduler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/quote_scheduler.sv
// Quote scheduler: turns bid/ask quote pairs into two-beat gateway orders with cooldown, latest-wins pending and crossed-quote rejection.
// Optional build macro QUOTE_SCHED_DEDUP_EN suppresses resending a pair identical to the last one sent.
module quote_scheduler #(
  parameter int DATA_WIDTH      = 32,
  parameter int COOLDOWN_CYCLES = 16,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_buy_price,
  input  logic [DATA_WIDTH-1:0] i_ask_price,
  input  logic                  i_data_valid,
  output logic [DATA_WIDTH-1:0] o_order_price,
  output logic                  o_order_side,
  output logic                  o_order_valid,
  input  logic                  i_order_ready,
  output logic                  o_busy,
  output logic [CNT_WIDTH-1:0]  o_drop_count
);

  localparam int CoolW    = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
  localparam int CoolLoad = (COOLDOWN_CYCLES > 0) ? COOLDOWN_CYCLES - 1 : 0;

  typedef enum logic [1:0] {IDLE, SEND_BID, SEND_ASK, COOLDOWN} state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [DATA_WIDTH-1:0] r_pendBuy;
  logic [DATA_WIDTH-1:0] r_pendAsk;
  logic                  r_pendValid;
  logic [DATA_WIDTH-1:0] r_workBuy;
  logic [DATA_WIDTH-1:0] r_workAsk;
  logic [CoolW-1:0]      r_coolCnt;
  logic [CNT_WIDTH-1:0]  r_dropCount;
  logic                  w_consume;
  logic                  w_crossed;
  logic                  w_dup;
  logic                  w_accept;
  logic                  w_askFire;
  logic                  w_dropInc;

`ifdef QUOTE_SCHED_DEDUP_EN
  logic [DATA_WIDTH-1:0] r_lastBuy;
  logic [DATA_WIDTH-1:0] r_lastAsk;
  logic                  r_lastValid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lastBuy   <= '0;
      r_lastAsk   <= '0;
      r_lastValid <= 1'b0;
    end else if (w_askFire) begin
      r_lastBuy   <= r_workBuy;
      r_lastAsk   <= r_workAsk;
      r_lastValid <= 1'b1;
    end
  end

  assign w_dup = r_lastValid && (r_pendBuy == r_lastBuy) && (r_pendAsk == r_lastAsk);
`else
  assign w_dup = 1'b0;
`endif

  // A pending pair is consumed whenever IDLE looks at it, whether it is sent or discarded.
  always_comb begin
    w_consume = (r_state == IDLE) && r_pendValid;
    w_crossed = (r_pendBuy >= r_pendAsk);
    w_accept  = w_consume && !w_crossed && !w_dup;
    w_askFire = (r_state == SEND_ASK) && i_order_ready;
    w_dropInc = (i_data_valid && r_pendValid && !w_consume) || (w_consume && w_crossed);
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:     if (w_accept) w_nextState = SEND_BID;
      SEND_BID: if (i_order_ready) w_nextState = SEND_ASK;
      SEND_ASK: if (i_order_ready) w_nextState = (COOLDOWN_CYCLES == 0) ? IDLE : COOLDOWN;
      COOLDOWN: if (r_coolCnt == '0) w_nextState = IDLE;
      default:  w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_nextState;
  end

  // A new capture overrides a same-cycle consume, so the flag stays set.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pendBuy   <= '0;
      r_pendAsk   <= '0;
      r_pendValid <= 1'b0;
    end else if (i_data_valid) begin
      r_pendBuy   <= i_buy_price;
      r_pendAsk   <= i_ask_price;
      r_pendValid <= 1'b1;
    end else if (w_consume) begin
      r_pendValid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_workBuy <= '0;
      r_workAsk <= '0;
    end else if (w_accept) begin
      r_workBuy <= r_pendBuy;
      r_workAsk <= r_pendAsk;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                    r_coolCnt <= '0;
    else if (w_askFire)                              r_coolCnt <= CoolW'(CoolLoad);
    else if (r_state == COOLDOWN && r_coolCnt != '0) r_coolCnt <= r_coolCnt - 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                               r_dropCount <= '0;
    else if (w_dropInc && r_dropCount != '1)    r_dropCount <= r_dropCount + 1'b1;
  end

  // Decoded from state so an async reset drops the beat without waiting for a clock.
  always_comb begin
    o_order_valid = 1'b0;
    o_order_side  = 1'b0;
    o_order_price = '0;
    case (r_state)
      SEND_BID: begin
        o_order_valid = 1'b1;
        o_order_price = r_workBuy;
      end
      SEND_ASK: begin
        o_order_valid = 1'b1;
        o_order_side  = 1'b1;
        o_order_price = r_workAsk;
      end
      default: ;
    endcase
    o_busy       = (r_state != IDLE);
    o_drop_count = r_dropCount;
  end

endmodule

// File: tb/tb_quote_scheduler.sv
// Directed testbench for quote_scheduler; a 2-bit drop counter makes saturation reachable.
module tb_quote_scheduler;

  localparam int DW = 32;
  localparam int CD = 16;
  localparam int CW = 2;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic [DW-1:0] i_buy_price;
  logic [DW-1:0] i_ask_price;
  logic          i_data_valid;
  logic [DW-1:0] o_order_price;
  logic          o_order_side;
  logic          o_order_valid;
  logic          i_order_ready;
  logic          o_busy;
  logic [CW-1:0] o_drop_count;

  int nAsserts = 0;
  int nFails   = 0;

  quote_scheduler #(.DATA_WIDTH(DW), .COOLDOWN_CYCLES(CD), .CNT_WIDTH(CW)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_buy_price   (i_buy_price),
    .i_ask_price   (i_ask_price),
    .i_data_valid  (i_data_valid),
    .o_order_price (o_order_price),
    .o_order_side  (o_order_side),
    .o_order_valid (o_order_valid),
    .i_order_ready (i_order_ready),
    .o_busy        (o_busy),
    .o_drop_count  (o_drop_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic applyStimulus(input logic [DW-1:0] buy, input logic [DW-1:0] ask, input logic dv);
    i_buy_price  = buy;
    i_ask_price  = ask;
    i_data_valid = dv;
  endtask

  task automatic sendQuote(input logic [DW-1:0] buy, input logic [DW-1:0] ask);
    applyStimulus(buy, ask, 1'b1);
    tick();
    applyStimulus(buy, ask, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
    nAsserts++;
    assert (observed === expected) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkBeat(input string tag, input logic v, input logic s, input logic [DW-1:0] p);
    checkOutput({tag, ".valid"}, DW'(o_order_valid), DW'(v));
    checkOutput({tag, ".side"},  DW'(o_order_side),  DW'(s));
    checkOutput({tag, ".price"}, o_order_price,      p);
  endtask

  task automatic checkBusy(input string tag, input logic b);
    checkOutput({tag, ".busy"}, DW'(o_busy), DW'(b));
  endtask

  task automatic checkDrops(input string tag, input int d);
    checkOutput({tag, ".drop"}, DW'(o_drop_count), DW'(d));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    i_rst_n       = 1'b0;
    i_order_ready = 1'b0;
    applyStimulus('0, '0, 1'b0);
    ticks(2);
    checkBeat("reset", 1'b0, 1'b0, 0);
    checkBusy("reset", 1'b0);
    checkDrops("reset", 0);
    i_rst_n = 1'b1;
    tick();

    $display("[TB] basic pair 100/104 with ready high");
    i_order_ready = 1'b1;
    sendQuote(100, 104);
    checkBeat("t1.e0", 1'b0, 1'b0, 0);
    tick();
    checkBeat("t1.bid", 1'b1, 1'b0, 100);
    checkBusy("t1.bid", 1'b1);
    tick();
    checkBeat("t1.ask", 1'b1, 1'b1, 104);
    tick();
    checkBeat("t1.cool", 1'b0, 1'b0, 0);
    checkBusy("t1.cool0", 1'b1);
    for (int i = 0; i < CD - 1; i++) begin
      tick();
      checkBusy("t1.cool", 1'b1);
    end
    tick();
    checkBusy("t1.idle", 1'b0);

    $display("[TB] crossed quote 105/105");
    sendQuote(105, 105);
    checkDrops("t2.e0", 0);
    tick();
    checkDrops("t2.e1", 1);
    checkBusy("t2.e1", 1'b0);
    tick();
    checkBeat("t2.none", 1'b0, 1'b0, 0);
    checkBusy("t2.none", 1'b0);

    $display("[TB] backpressure on bid beat, 200/210 replaces pending");
    i_order_ready = 1'b0;
    sendQuote(50, 60);
    tick();
    checkBeat("t3.bid", 1'b1, 1'b0, 50);
    for (int i = 0; i < 5; i++) begin
      if (i == 0) applyStimulus(200, 210, 1'b1);
      tick();
      if (i == 0) applyStimulus(200, 210, 1'b0);
      checkBeat("t3.hold", 1'b1, 1'b0, 50);
    end
    checkDrops("t3.hold", 1);
    i_order_ready = 1'b1;
    tick();
    checkBeat("t3.ask", 1'b1, 1'b1, 60);
    tick();
    checkBeat("t3.cool", 1'b0, 1'b0, 0);
    ticks(CD);
    checkBusy("t3.idle", 1'b0);
    checkBeat("t3.idle", 1'b0, 1'b0, 0);
    tick();
    checkBeat("t3.bid2", 1'b1, 1'b0, 200);
    tick();
    checkBeat("t3.ask2", 1'b1, 1'b1, 210);
    tick();
    checkBusy("t3.cool2", 1'b1);
    checkDrops("t3.end", 1);

    $display("[TB] three quotes during cooldown, latest wins");
    applyStimulus(10, 20, 1'b1);
    tick();
    checkDrops("t4.q1", 1);
    applyStimulus(11, 21, 1'b1);
    tick();
    checkDrops("t4.q2", 2);
    applyStimulus(12, 22, 1'b1);
    tick();
    applyStimulus(12, 22, 1'b0);
    checkDrops("t4.q3", 3);
    ticks(CD - 3);
    checkBusy("t4.idle", 1'b0);
    tick();
    checkBeat("t4.bid", 1'b1, 1'b0, 12);
    tick();
    checkBeat("t4.ask", 1'b1, 1'b1, 22);
    tick();
    ticks(CD);
    checkBusy("t4.idle2", 1'b0);

    $display("[TB] saturating drop counter");
    sendQuote(9, 9);
    tick();
    checkDrops("t4.sat", 3);
    checkBusy("t4.sat", 1'b0);

    $display("[TB] reset asserted during ask beat");
    sendQuote(30, 40);
    tick();
    checkBeat("t5.bid", 1'b1, 1'b0, 30);
    applyStimulus(70, 80, 1'b1);
    tick();
    applyStimulus(70, 80, 1'b0);
    checkBeat("t5.ask", 1'b1, 1'b1, 40);
    #1 i_rst_n = 1'b0;
    #1;
    checkBeat("t5.async", 1'b0, 1'b0, 0);
    checkBusy("t5.async", 1'b0);
    checkDrops("t5.async", 0);
    tick();
    i_rst_n = 1'b1;
    ticks(2);
    checkBeat("t5.after", 1'b0, 1'b0, 0);
    checkBusy("t5.after", 1'b0);
    checkDrops("t5.after", 0);

    $display("[TB] repeated pair 100/104 then 100/105");
    sendQuote(100, 104);
    tick();
    checkBeat("t6.bid1", 1'b1, 1'b0, 100);
    tick();
    checkBeat("t6.ask1", 1'b1, 1'b1, 104);
    tick();
    ticks(CD);
    checkBusy("t6.idle1", 1'b0);
    sendQuote(100, 104);
    tick();
`ifdef QUOTE_SCHED_DEDUP_EN
    checkBeat("t6.dup", 1'b0, 1'b0, 0);
    checkBusy("t6.dup", 1'b0);
    checkDrops("t6.dup", 0);
    tick();
    checkBeat("t6.dup2", 1'b0, 1'b0, 0);
`else
    checkBeat("t6.bid2", 1'b1, 1'b0, 100);
    tick();
    checkBeat("t6.ask2", 1'b1, 1'b1, 104);
    tick();
    ticks(CD);
    checkBusy("t6.idle2", 1'b0);
    checkDrops("t6.resend", 0);
`endif
    sendQuote(100, 105);
    tick();
    checkBeat("t6.bid3", 1'b1, 1'b0, 100);
    tick();
    checkBeat("t6.ask3", 1'b1, 1'b1, 105);
    checkDrops("t6.end", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
